// File: rtl/imem_loader.sv
// Boot-time program loader. Consumes a little-endian byte stream (4-byte word
// count N, then N little-endian instruction words), writes each assembled
// word into instruction memory at byte address 4*i, and holds the processor
// stalled until the whole image has been written.
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] words_loaded,
    output logic             cpu_run,
    output logic             done,
    output logic             err_overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_lo;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_idx;
    logic [31:0]      cur_word;
    logic             xfer;

    // Word completed by the byte currently on the bus (valid only when byte_idx==3).
    always_comb begin
        cur_word = {byte_in, asm_lo};
        xfer     = byte_valid & byte_ready;
    end

    // Loader state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            byte_idx     <= '0;
            asm_lo       <= '0;
            count        <= '0;
            word_idx     <= '0;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            cpu_run      <= 1'b0;
            done         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            // Low three bytes are latched as they arrive; the fourth is used
            // straight from the bus so the word completes on its own edge.
            if (xfer) begin
                case (byte_idx)
                    2'd0:    asm_lo[7:0]   <= byte_in;
                    2'd1:    asm_lo[15:8]  <= byte_in;
                    2'd2:    asm_lo[23:16] <= byte_in;
                    default: ;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state      <= S_HDR;
                        byte_idx   <= '0;
                        byte_ready <= 1'b1;
                    end
                end

                S_HDR: begin
                    if (xfer && byte_idx == 2'd3) begin
                        count      <= CNT_W'(cur_word);
                        byte_ready <= 1'b0;
                        if (cur_word == 32'd0) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else if (cur_word > 32'(DEPTH_WORDS)) begin
                            state        <= S_ERR;
                            err_overflow <= 1'b1;
                        end else begin
                            state      <= S_LOAD;
                            byte_ready <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (xfer && byte_idx == 2'd3) begin
                        state      <= S_WRITE;
                        byte_ready <= 1'b0;
                        imem_we    <= 1'b1;
                        imem_addr  <= 32'(word_idx) << 2;
                        imem_wdata <= cur_word;
                    end
                end

                S_WRITE: begin
                    imem_we      <= 1'b0;
                    word_idx     <= word_idx + CNT_W'(1);
                    words_loaded <= words_loaded + CNT_W'(1);
                    if (word_idx + CNT_W'(1) == count) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state      <= S_LOAD;
                        byte_ready <= 1'b1;
                    end
                end

                S_DONE, S_ERR: begin
                    if (load_start) begin
                        state        <= S_HDR;
                        byte_idx     <= '0;
                        word_idx     <= '0;
                        words_loaded <= '0;
                        byte_ready   <= 1'b1;
                        cpu_run      <= 1'b0;
                        done         <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
